// File: rtl/jtkcpu_stkseq.sv
// Stack sequencer for PSHS/PSHU/PULS/PULU.
// Walks the postbyte mask one byte per bus cycle, owns a working SP, writes it back.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   psh_go, pul_go       start push / pull (taken only when idle)
//   mask                 postbyte register mask (b7 PC .. b0 CC)
//   sp_in                stack pointer latched on go
//   mem_ack              bus cycle complete
//   busy                 sequence in progress
//   reg_sel, hi_byte     register / byte being transferred
//   mem_req, mem_we      bus request (held until ack) and direction
//   mem_addr             byte address of current cycle
//   pul_we               strobe: load read byte into reg_sel/hi_byte
//   sp_out, sp_we        final stack pointer and write-back strobe
//   done                 end-of-sequence strobe
module jtkcpu_stkseq #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          psh_go,
  input  logic          pul_go,
  input  logic [7:0]    mask,
  input  logic [AW-1:0] sp_in,
  input  logic          mem_ack,
  output logic          busy,
  output logic [2:0]    reg_sel,
  output logic          hi_byte,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic          pul_we,
  output logic [AW-1:0] sp_out,
  output logic          sp_we,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } st_t;

  localparam logic [AW-1:0] ONE = AW'(1);

  st_t           st_q, st_d;
  logic [7:0]    pend_q, pend_d;
  logic [AW-1:0] wsp_q, wsp_d;
  logic          push_q, push_d;
  logic          sec_q, sec_d;

  logic [2:0]    cur;
  logic          wide;
  logic          last;
  logic          hi;
  logic [7:0]    clr;

  // Push serves the highest pending bit, pull the lowest:
  // the loop's last hit wins.
  always_comb begin
    cur = 3'd0;
    if (push_q) begin
      for (int i = 0; i < 8; i++)
        if (pend_q[i]) cur = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (pend_q[i]) cur = 3'(i);
    end
  end

  // sec_q marks the second byte of a 16-bit register.
  // Push goes low->high, pull goes high->low.
  assign wide = cur[2];
  assign last = ~wide | sec_q;
  assign hi   = wide & (push_q ? sec_q : ~sec_q);
  assign clr  = pend_q & ~(8'b1 << cur);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      pend_q <= '0;
      wsp_q  <= '0;
      push_q <= 1'b0;
      sec_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      pend_q <= pend_d;
      wsp_q  <= wsp_d;
      push_q <= push_d;
      sec_q  <= sec_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    pend_d   = pend_q;
    wsp_d    = wsp_q;
    push_d   = push_q;
    sec_d    = sec_q;
    busy     = 1'b0;
    reg_sel  = 3'd0;
    hi_byte  = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    pul_we   = 1'b0;
    sp_out   = '0;
    sp_we    = 1'b0;
    done     = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (psh_go | pul_go) begin
          pend_d = mask;
          wsp_d  = sp_in;
          push_d = psh_go;
          sec_d  = 1'b0;
          st_d   = (mask == 8'h00) ? FIN : XFER;
        end
      end
      XFER: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_we   = push_q;
        mem_addr = push_q ? wsp_q - ONE : wsp_q;
        reg_sel  = cur;
        hi_byte  = hi;
        if (mem_ack) begin
          pul_we = ~push_q;
          wsp_d  = push_q ? wsp_q - ONE : wsp_q + ONE;
          if (last) begin
            pend_d = clr;
            sec_d  = 1'b0;
            if (clr == 8'h00) st_d = FIN;
          end else begin
            sec_d = 1'b1;
          end
        end
      end
      FIN: begin
        busy   = 1'b1;
        sp_out = wsp_q;
        sp_we  = 1'b1;
        done   = 1'b1;
        st_d   = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_jtkcpu_stkseq.sv
// Directed bench for jtkcpu_stkseq.
// Drives go/ack, checks every bus byte, final SP and timing.
module tb_jtkcpu_stkseq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psh_go = 1'b0;
  logic        pul_go = 1'b0;
  logic [7:0]  mask = 8'h00;
  logic [15:0] sp_in = 16'h0000;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic [2:0]  reg_sel;
  logic        hi_byte;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic        pul_we;
  logic [15:0] sp_out;
  logic        sp_we;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [15:0] ea[16];
  logic [2:0]  es[16];
  logic        eh[16];

  jtkcpu_stkseq #(.AW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .psh_go   (psh_go),
    .pul_go   (pul_go),
    .mask     (mask),
    .sp_in    (sp_in),
    .mem_ack  (mem_ack),
    .busy     (busy),
    .reg_sel  (reg_sel),
    .hi_byte  (hi_byte),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .pul_we   (pul_we),
    .sp_out   (sp_out),
    .sp_we    (sp_we),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic setx(input int k, input logic [15:0] a,
                      input logic [2:0] s, input logic h);
    ea[k] = a;
    es[k] = s;
    eh[k] = h;
  endtask

  // wn: wait cycles before ack on each byte
  task automatic run(input string tag, input logic ps, input logic pl,
                     input logic [7:0] m, input logic [15:0] sp,
                     input int wn, input int nb, input int dcyc,
                     input logic [15:0] esp, input logic ewe);
    int k;
    int wc;
    int dc;
    k  = 0;
    wc = 0;
    dc = -1;
    @(negedge clk);
    psh_go = ps;
    pul_go = pl;
    mask   = m;
    sp_in  = sp;
    for (int cyc = 1; cyc <= 200 && dc < 0; cyc++) begin
      @(posedge clk);
      #1;
      psh_go = 1'b0;
      pul_go = 1'b0;
      if (mem_req) begin
        wc++;
        mem_ack = (wc > wn);
      end else begin
        mem_ack = 1'b0;
      end
      @(negedge clk);
      chk({tag, ".busy"}, busy, 1);
      if (mem_req) begin
        if (k < nb) begin
          chk($sformatf("%s.addr%0d", tag, k), mem_addr, ea[k]);
          chk($sformatf("%s.sel%0d", tag, k), reg_sel, es[k]);
          chk($sformatf("%s.hi%0d", tag, k), hi_byte, eh[k]);
          chk($sformatf("%s.we%0d", tag, k), mem_we, ewe);
        end else begin
          chk({tag, ".extra"}, mem_req, 0);
        end
        if (mem_ack) begin
          chk($sformatf("%s.pwe%0d", tag, k), pul_we, !ewe);
          k++;
          wc = 0;
        end
      end
      if (done) begin
        dc = cyc;
        chk({tag, ".dcyc"}, dc, dcyc);
        chk({tag, ".sp"}, sp_out, esp);
        chk({tag, ".spwe"}, sp_we, 1);
        chk({tag, ".nbytes"}, k, nb);
      end
    end
    if (dc < 0) chk({tag, ".timeout"}, done, 1);
    @(posedge clk);
    #1 mem_ack = 1'b0;
    @(negedge clk);
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".done0"}, done, 0);
  endtask

  initial begin
    @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.req", mem_req, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.done", done, 0);
    chk("rst.spwe", sp_we, 0);
    chk("rst.sp", sp_out, 0);
    rst = 1'b0;

    setx(0, 16'h0FFF, 3'd7, 1'b0);
    setx(1, 16'h0FFE, 3'd7, 1'b1);
    setx(2, 16'h0FFD, 3'd6, 1'b0);
    setx(3, 16'h0FFC, 3'd6, 1'b1);
    setx(4, 16'h0FFB, 3'd5, 1'b0);
    setx(5, 16'h0FFA, 3'd5, 1'b1);
    setx(6, 16'h0FF9, 3'd4, 1'b0);
    setx(7, 16'h0FF8, 3'd4, 1'b1);
    setx(8, 16'h0FF7, 3'd3, 1'b0);
    setx(9, 16'h0FF6, 3'd2, 1'b0);
    setx(10, 16'h0FF5, 3'd1, 1'b0);
    setx(11, 16'h0FF4, 3'd0, 1'b0);
    run("pshFF", 1, 0, 8'hFF, 16'h1000, 0, 12, 13, 16'h0FF4, 1);

    setx(0, 16'h0FF4, 3'd0, 1'b0);
    setx(1, 16'h0FF5, 3'd7, 1'b1);
    setx(2, 16'h0FF6, 3'd7, 1'b0);
    run("pul81", 0, 1, 8'h81, 16'h0FF4, 0, 3, 4, 16'h0FF7, 0);

    run("pul00", 0, 1, 8'h00, 16'h1234, 0, 0, 1, 16'h1234, 0);

    setx(0, 16'hFFFF, 3'd2, 1'b0);
    setx(1, 16'hFFFE, 3'd1, 1'b0);
    run("psh06", 1, 0, 8'h06, 16'h0000, 0, 2, 3, 16'hFFFE, 1);

    setx(0, 16'h1FFF, 3'd4, 1'b0);
    setx(1, 16'h1FFE, 3'd4, 1'b1);
    run("both10", 1, 1, 8'h10, 16'h2000, 3, 2, 9, 16'h1FFE, 1);

    // reset during the second byte of a full push
    @(negedge clk);
    psh_go = 1'b1;
    mask   = 8'hFF;
    sp_in  = 16'h1000;
    @(posedge clk);
    #1;
    psh_go  = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    chk("abort.b0", mem_addr, 16'h0FFF);
    @(posedge clk);
    #1;
    chk("abort.b1", mem_addr, 16'h0FFE);
    rst = 1'b1;
    #1;
    chk("abort.req", mem_req, 0);
    chk("abort.busy", busy, 0);
    chk("abort.addr", mem_addr, 0);
    chk("abort.sel", reg_sel, 0);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort.done", done, 0);
      chk("abort.spwe", sp_we, 0);
    end
    rst = 1'b0;
    run("post", 0, 1, 8'h00, 16'h5555, 0, 0, 1, 16'h5555, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
